log2_32b_rr_scheduler: RTL and testbench
========================================

Name: log2_32b_rr_scheduler

Overview:
Shares one combinational log2_32b instance (in0[31:0] -> out0[31:0]) between NREQ independent requesters. Arbitration is round-robin over valid/ready request channels. The result is registered into a one-entry output slot, tagged with the requester ID, and drained through a valid/ready response channel. It sits between client blocks and the approximate/exact log2 datapath, so that datapath can be swapped without touching the clients.

Parameters:
NREQ, 4, number of requesters; legal range 2..16
IDW, 2, width of resp_id; NREQ <= 2**IDW is required
CNTW, 16, width of the served-response counter

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  grant enable; 0 blocks new grants, drain continues
req_valid  input  NREQ  request valid, bit i = requester i
req_data  input  NREQ*32  operands; requester i at [32*i+31:32*i]
req_ready  output  NREQ  one-hot (or zero) grant/accept
resp_valid  output  1  output slot holds a result
resp_ready  input  1  consumer accepts result
resp_data  output  32  log2_32b result for the granted operand
resp_id  output  IDW  index of the requester that produced resp_data
served_cnt  output  CNTW  count of completed response handshakes

Behaviour:
- Reset values (rst_n low, asynchronous): resp_valid=0, resp_data=0, resp_id=0, served_cnt=0, rr pointer last_grant=NREQ-1, so requester 0 has first priority. req_ready=0 while rst_n is low.
- Reset mid-operation: any held result is discarded. resp_valid falls without waiting for a clock edge. No handshake is counted.
- can_accept = en && (!resp_valid || resp_ready).
- Grant selection (combinational): when can_accept, search from (last_grant+1) mod NREQ upward with wrap. The first i with req_valid[i]=1 gets req_ready[i]=1. All other bits are 0. With no valid requester, or with can_accept=0, req_ready is 0.
- req_ready depends on req_valid. Requesters must not make req_valid depend on req_ready.
- Transfer on edge where req_valid[g] && req_ready[g]:
  - resp_data <= out0 of the shared instance driven by req_data[g]
  - resp_id <= g
  - resp_valid <= 1
  - last_grant <= g
- The shared instance input is muxed from req_data of the granted requester. With no grant the mux selects requester last_grant, which holds the input stable and limits switching.
- Latency is 1 cycle from request handshake to resp_valid. Throughput is 1 result per cycle while resp_ready=1.
- Output slot:
  - resp_valid && resp_ready with no new grant on the same edge -> resp_valid <= 0.
  - A simultaneous new grant refills the slot on the same edge, with no bubble.
  - While resp_valid && !resp_ready, resp_data and resp_id hold stable and req_ready is all 0.
- served_cnt increments by 1 on each resp_valid && resp_ready edge and wraps from 2**CNTW-1 to 0.
- en=0: no grants and last_grant frozen. The pending result still drains normally. Re-asserting en resumes from the frozen pointer.
- A requester that drops req_valid before it is granted is simply skipped. Requests are never queued internally.
- Requester indices >= NREQ never appear on resp_id.
- No combinational path exists from resp_ready to resp_data or resp_id. There is a combinational path from resp_ready to req_ready.

Test Plan:
1. Hold rst_n=0 with all req_valid=1 -> req_ready=0, resp_valid=0, resp_id=0, served_cnt=0. After release with en=1, the first grant is requester 0.
2. Only requester 2 valid with req_data[95:64]=0x00000400, resp_ready=1 -> req_ready=4'b0100 that cycle. Next cycle resp_valid=1, resp_id=2, resp_data equals log2_32b(0x00000400) from the golden model. One edge later served_cnt=1.
3. All four requesters valid continuously, resp_ready=1, en=1 -> grant order 0,1,2,3,0,1 on consecutive cycles. resp_id follows one cycle later with no bubbles. served_cnt=6 after six handshakes.
4. Backpressure: resp_ready=0 for 5 cycles with the slot full (resp_id=1) -> req_ready=0 and resp_data/resp_id unchanged throughout. Raising resp_ready grants requester 2 in the same cycle, and the next cycle shows resp_id=2.
5. Set en=0 while the slot holds resp_id=3, with resp_ready=1 -> the slot drains (resp_valid=0 next cycle) and no grants follow. Setting en=1 grants requester 0 next.
6. Pull rst_n low asynchronously mid-cycle while resp_valid=1 and served_cnt=9 -> resp_valid=0 and served_cnt=0 before the next clk edge. After release, requester 0 is granted first. The discarded result is never observed at the output.

Source files
------------

// File: rtl/log2_32b_rr_scheduler.sv
// Round-robin front end that time-shares one combinational log2_32b datapath
// between NREQ valid/ready requesters, with a one-entry tagged result slot.

// Mitchell-style log2: out0 = Q5.27 {floor(log2(in0)), mantissa below the leading one}.
// in0 == 0 maps to 0.
module log2_32b (
  input  logic [31:0] in0,
  output logic [31:0] out0
);
  logic [4:0] msb;

  always_comb begin
    msb = '0;
    for (int i = 0; i < 32; i++)
      if (in0[i]) msb = 5'(i);
    // Right-aligning {in0, 27 zeros} by msb leaves the fraction in the low 27 bits.
    out0 = (in0 == '0) ? '0 : {msb, 27'({in0, 27'b0} >> msb)};
  end
endmodule

// Per-requester term: valid and strictly above the round-robin pointer.
module log2_rr_lane #(
  parameter int IDX = 0,
  parameter int IDW = 2
) (
  input  logic           vld,
  input  logic [IDW-1:0] ptr,
  output logic           hi
);
  assign hi = vld && (IDW'(IDX) > ptr);
endmodule

module log2_32b_rr_scheduler #(
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int CNTW = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*32-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_data,
  output logic [IDW-1:0]    resp_id,
  output logic [CNTW-1:0]   served_cnt
);
  logic [IDW-1:0]  last_grant;
  logic [NREQ-1:0] hi_req;
  logic [NREQ-1:0] cand;
  logic [IDW-1:0]  gidx;
  logic [IDW-1:0]  sel;
  logic            can_accept;
  logic            any_grant;
  logic [31:0]     in0;
  logic [31:0]     out0;

  // rst_n gates acceptance so nothing is offered while reset is held.
  assign can_accept = rst_n && en && (!resp_valid || resp_ready);

  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    log2_rr_lane #(.IDX(i), .IDW(IDW)) u_lane (
      .vld (req_valid[i]),
      .ptr (last_grant),
      .hi  (hi_req[i])
    );
  end

  // Lowest valid index above the pointer wins; otherwise wrap to the lowest valid.
  always_comb begin
    cand      = (|hi_req) ? hi_req : req_valid;
    any_grant = can_accept && (|req_valid);
    gidx      = '0;
    for (int i = NREQ - 1; i >= 0; i--)
      if (cand[i]) gidx = IDW'(i);
    req_ready = '0;
    for (int i = 0; i < NREQ; i++)
      req_ready[i] = any_grant && (gidx == IDW'(i));
  end

  // Idle mux parks on last_grant to keep the datapath input quiet.
  assign sel = any_grant ? gidx : last_grant;

  always_comb begin
    in0 = '0;
    for (int i = 0; i < NREQ; i++)
      if (sel == IDW'(i)) in0 = req_data[32*i +: 32];
  end

  log2_32b u_log2 (
    .in0  (in0),
    .out0 (out0)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_id    <= '0;
      last_grant <= IDW'(NREQ - 1);
      served_cnt <= '0;
    end else begin
      if (resp_valid && resp_ready) served_cnt <= served_cnt + CNTW'(1);
      if (any_grant) begin
        resp_valid <= 1'b1;
        resp_data  <= out0;
        resp_id    <= gidx;
        last_grant <= gidx;
      end else if (resp_ready) begin
        resp_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_log2_32b_rr_scheduler.sv
// Self-checking bench: log2 vector table, directed multi-cycle sequences and a
// randomized run against a queue-free behavioural model of the scheduler.
module tb_log2_32b_rr_scheduler;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int CNTW = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              en;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*32-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_data;
  logic [IDW-1:0]    resp_id;
  logic [CNTW-1:0]   served_cnt;

  int checks = 0;
  int errors = 0;

  log2_32b_rr_scheduler #(.NREQ(NREQ), .IDW(IDW), .CNTW(CNTW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_id    (resp_id),
    .served_cnt (served_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference log2: k = floor(log2 x), fraction = (x - 2^k) / 2^k in Q0.27.
  function automatic logic [31:0] log2ref(input logic [31:0] x);
    int k;
    longint unsigned f;
    if (x == 0) return 32'd0;
    k = 0;
    while ((64'(x) >> (k + 1)) != 0) k++;
    f = ((64'(x) - (64'd1 << k)) << 27) >> k;
    return {5'(k), 27'(f)};
  endfunction

  function automatic logic [31:0] dword(input logic [NREQ*32-1:0] d, input int i);
    return d[32*i +: 32];
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req_valid = '0; en = 1'b1; resp_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  vec_t vt[9];
  int ptr, g, sid;
  logic sv;
  logic [31:0] sd;
  logic [CNTW-1:0] cnt;
  logic [NREQ-1:0] exp_rdy;
  logic ca;

  initial begin
    vt[0] = '{32'h0000_0000, 32'h0000_0000};
    vt[1] = '{32'h0000_0001, 32'h0000_0000};
    vt[2] = '{32'h0000_0002, 32'h0800_0000};
    vt[3] = '{32'h0000_0003, 32'h0C00_0000};
    vt[4] = '{32'h0000_0006, 32'h1400_0000};
    vt[5] = '{32'h0000_0400, 32'h5000_0000};
    vt[6] = '{32'h3000_0000, 32'hEC00_0000};
    vt[7] = '{32'h8000_0000, 32'hF800_0000};
    vt[8] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF};

    for (int i = 0; i < NREQ; i++) req_data[32*i +: 32] = 32'h100 << (4 * i);

    // 1: reset holds everything off even with all requesters valid
    rst_n = 1'b0; en = 1'b1; req_valid = 4'hF; resp_ready = 1'b1;
    #12;
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_resp_valid", 32'(resp_valid), 32'h0);
    chk("rst_resp_id", 32'(resp_id), 32'h0);
    chk("rst_served_cnt", 32'(served_cnt), 32'h0);
    @(negedge clk); rst_n = 1'b1; #1;
    chk("rst_first_grant", 32'(req_ready), 32'h1);

    // log2 vector table through rotating single requesters
    do_reset();
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      req_valid = 4'(1 << (i % NREQ));
      req_data[32*(i % NREQ) +: 32] = vt[i].x;
      @(posedge clk); #1;
      chk($sformatf("vec%0d_data", i), resp_data, vt[i].y);
      chk($sformatf("vec%0d_id", i), 32'(resp_id), 32'(i % NREQ));
    end
    req_valid = '0;

    // 2: single requester 2
    do_reset();
    req_data[95:64] = 32'h0000_0400; req_valid = 4'b0100; #1;
    chk("t2_ready", 32'(req_ready), 32'b0100);
    @(posedge clk); #1;
    req_valid = '0;
    chk("t2_valid", 32'(resp_valid), 32'h1);
    chk("t2_id", 32'(resp_id), 32'h2);
    chk("t2_data", resp_data, log2ref(32'h0000_0400));
    @(posedge clk); #1;
    chk("t2_cnt", 32'(served_cnt), 32'h1);

    // 3: all valid, round-robin with no bubbles
    do_reset();
    for (int i = 0; i < NREQ; i++) req_data[32*i +: 32] = 32'h11 * (i + 3);
    req_valid = 4'hF;
    for (int c = 0; c < 6; c++) begin
      #1;
      chk($sformatf("t3_ready%0d", c), 32'(req_ready), 32'(1 << (c % NREQ)));
      @(posedge clk); #1;
      if (c == 5) req_valid = '0;
      chk($sformatf("t3_id%0d", c), 32'(resp_id), 32'(c % NREQ));
      chk($sformatf("t3_data%0d", c), resp_data, log2ref(dword(req_data, c % NREQ)));
      @(negedge clk);
    end
    @(posedge clk); #1;
    chk("t3_cnt", 32'(served_cnt), 32'd6);
    chk("t3_drained", 32'(resp_valid), 32'h0);

    // 4: backpressure holds slot, release grants next in rotation
    do_reset();
    resp_ready = 1'b0; req_valid = 4'b0010; #1;
    chk("t4_ready1", 32'(req_ready), 32'b0010);
    @(posedge clk); #1;
    req_valid = 4'hF;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("t4_bp_ready%0d", c), 32'(req_ready), 32'h0);
      chk($sformatf("t4_bp_id%0d", c), 32'(resp_id), 32'h1);
      chk($sformatf("t4_bp_data%0d", c), resp_data, log2ref(dword(req_data, 1)));
      @(posedge clk);
    end
    @(negedge clk); resp_ready = 1'b1; #1;
    chk("t4_release_ready", 32'(req_ready), 32'b0100);
    @(posedge clk); #1;
    req_valid = '0;
    chk("t4_id2", 32'(resp_id), 32'h2);
    chk("t4_cnt", 32'(served_cnt), 32'h1);

    // 5: en=0 drains slot and freezes grants
    do_reset();
    req_valid = 4'b1000;
    @(posedge clk); #1;
    en = 1'b0; req_valid = 4'hF; #1;
    chk("t5_id3", 32'(resp_id), 32'h3);
    chk("t5_ready_off", 32'(req_ready), 32'h0);
    @(posedge clk); #1;
    chk("t5_drained", 32'(resp_valid), 32'h0);
    chk("t5_ready_off2", 32'(req_ready), 32'h0);
    @(posedge clk); #1;
    chk("t5_still_empty", 32'(resp_valid), 32'h0);
    en = 1'b1; #1;
    chk("t5_resume", 32'(req_ready), 32'b0001);
    @(posedge clk); #1;
    req_valid = '0;

    // 6: asynchronous reset mid-cycle discards held result
    do_reset();
    req_valid = 4'hF;
    repeat (10) @(posedge clk);
    #1;
    chk("t6_pre_cnt", 32'(served_cnt), 32'd9);
    chk("t6_pre_valid", 32'(resp_valid), 32'h1);
    #2 rst_n = 1'b0; #1;
    chk("t6_async_valid", 32'(resp_valid), 32'h0);
    chk("t6_async_cnt", 32'(served_cnt), 32'h0);
    chk("t6_async_ready", 32'(req_ready), 32'h0);
    @(negedge clk); rst_n = 1'b1; #1;
    chk("t6_first_grant", 32'(req_ready), 32'b0001);
    @(posedge clk); #1;
    chk("t6_first_id", 32'(resp_id), 32'h0);
    req_valid = '0;

    // Randomized run against the behavioural model
    do_reset();
    ptr = NREQ - 1; sv = 1'b0; sd = '0; sid = 0; cnt = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      en = ($urandom_range(0, 9) != 0);
      req_valid = 4'($urandom);
      resp_ready = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < NREQ; i++)
        req_data[32*i +: 32] = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      #1;
      ca = en && (!sv || resp_ready);
      g = -1;
      if (ca)
        for (int k = 1; k <= NREQ; k++)
          if (g < 0 && req_valid[(ptr + k) % NREQ]) g = (ptr + k) % NREQ;
      exp_rdy = (g >= 0) ? 4'(1 << g) : 4'h0;
      chk($sformatf("rnd%0d_ready", cyc), 32'(req_ready), 32'(exp_rdy));
      @(posedge clk);
      if (sv && resp_ready) cnt = cnt + 1'b1;
      if (g >= 0) begin
        sv = 1'b1; sd = log2ref(dword(req_data, g)); sid = g; ptr = g;
      end else if (resp_ready) begin
        sv = 1'b0;
      end
      #1;
      chk($sformatf("rnd%0d_valid", cyc), 32'(resp_valid), 32'(sv));
      chk($sformatf("rnd%0d_cnt", cyc), 32'(served_cnt), 32'(cnt));
      if (sv) begin
        chk($sformatf("rnd%0d_data", cyc), resp_data, sd);
        chk($sformatf("rnd%0d_id", cyc), 32'(resp_id), 32'(sid));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
